instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that initiates reads to the synchronous word-indexed instruction memory and delivers instructions to the IF/ID boundary. It owns the fetch PC, drives the memory address every cycle, and tracks the 1-cycle read latency. It absorbs decode-stage stalls with a hold buffer and squashes wrong-path fetches on branch/jump redirects. It sits between the PC-redirect logic in EX and the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000: byte address of the first fetch after reset; bits [1:0] must be 0.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_addr  out  32  word index to the instruction memory: {2'b00, fetch_pc[31:2]}. Combinational from the fetch_pc register.
- imem_data  in  32  memory read data, registered in memory; equals mem[imem_addr] sampled at the previous edge.
- id_stall  in  1  decode cannot accept this cycle; the current if_instr/if_pc must be presented again next cycle.
- redirect  in  1  taken branch or jump from EX; current and in-flight fetches are wrong-path.
- redirect_pc  in  32  byte target address; bits [1:0] ignored and treated as 0.
- if_instr  out  32  instruction to IF/ID.
- if_pc  out  32  byte address of if_instr.
- if_valid  out  1  if_instr/if_pc hold a real, correct-path instruction.

## Operation
- Registers: fetch_pc (address presented to memory), resp_pc (address whose data is on imem_data), resp_valid, hold_instr, state ∈ {RUN, STALL}.
- Reset (rst_n=0, immediate): fetch_pc=RESET_PC, resp_pc=0, resp_valid=0, hold_instr=0, state=RUN. Outputs during reset: if_valid=0, if_pc=0, if_instr=imem_data (don't care, not valid).
- Output mux: in RUN, if_instr=imem_data; in STALL, if_instr=hold_instr. In both states, if_pc=resp_pc and if_valid=resp_valid & ~redirect.
- Priority at each edge: redirect > id_stall > advance.
- redirect (any state): fetch_pc<=redirect_pc&~3, resp_valid<=0, state<=RUN, hold discarded.
- RUN, id_stall=1, no redirect: hold_instr<=imem_data, state<=STALL. fetch_pc, resp_pc and resp_valid hold. The memory keeps re-reading fetch_pc, which is the next sequential instruction.
- STALL, id_stall=1: all registers hold.
- RUN or STALL, id_stall=0, no redirect (advance): resp_pc<=fetch_pc, resp_valid<=1, fetch_pc<=fetch_pc+4, state<=RUN.
- Arithmetic: fetch_pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No error flag.
- id_stall while if_valid=0: state still enters STALL and the bubble is held. This is harmless; data is replayed unchanged.

## Timing
- Latency: the address is presented in cycle t and the instruction appears on if_instr in cycle t+1.
- Throughput: 1 instruction/cycle with no stall or redirect.
- After reset release: if_valid=0 in the first cycle. From the second cycle, if_pc=RESET_PC with if_valid=1. Thereafter if_pc advances +4 per cycle.
- Stall: if_instr and if_pc are stable for every cycle id_stall=1, plus the release cycle. The instruction after it appears the cycle after release with no gap.
- Redirect penalty: if_valid=0 in the redirect cycle and the next cycle. The target appears 2 cycles after the redirect edge.
- Simultaneous redirect and id_stall: redirect wins and the stall is ignored for fetch state.
- Reset mid-STALL: hold is discarded, state=RUN, and fetch restarts at RESET_PC.

## Test plan
- Reset release, RESET_PC=0, mem[k]=32'h1000_0000+k -> cycle 1 if_valid=0; cycles 2..5 show if_pc 0,4,8,12 and if_instr 32'h1000_0000..32'h1000_0003.
- id_stall high for 3 cycles while if_pc=8 -> if_pc=8 and if_instr=32'h1000_0002 for 4 cycles; next cycle if_pc=12 with 32'h1000_0003; no instruction lost or duplicated.
- redirect=1 with redirect_pc=32'h40 while if_pc=4 -> if_valid=0 that cycle and the next; then if_pc=32'h40, 32'h44 with mem[16] and mem[17].
- redirect together with id_stall, and redirect during STALL, redirect_pc=32'h23 -> state returns to RUN; target fetched at 32'h20; stall ignored; held instruction never re-emitted.
- rst_n pulsed low mid-STALL, asynchronously between edges -> if_valid drops to 0 immediately; after release the sequence restarts at RESET_PC as in scenario 1.
- fetch_pc wrap: redirect_pc=32'hFFFF_FFF8 -> if_pc shows FFFF_FFF8, FFFF_FFFC, 0000_0000 on consecutive valid cycles.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch stage. Owns the fetch PC, addresses the synchronous
//   word-indexed instruction memory every cycle and accounts for its one-cycle
//   read latency. Decode stalls are absorbed by a one-entry hold buffer.
//   Redirects from EX squash the current and in-flight fetches.
//
// Parameters
//   RESET_PC     byte address of the first fetch after reset (word aligned)
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_addr    word index presented to memory, {2'b00, fetch_pc[31:2]}
//   imem_data    memory read data for the address presented last cycle
//   id_stall     decode cannot accept; present the same instruction again
//   redirect     taken branch/jump from EX, squashes the wrong path
//   redirect_pc  byte target of the redirect (bits [1:0] ignored)
//   if_instr     instruction to IF/ID
//   if_pc        byte address of if_instr
//   if_valid     if_instr/if_pc hold a correct-path instruction
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        id_stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_valid
);

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StStall = 1'b1
   } state_e;

   state_e      state_q;
   logic [31:0] fetch_pc_q;
   logic [31:0] resp_pc_q;
   logic        resp_valid_q;
   logic [31:0] hold_instr_q;

   // Byte-offset bits of the redirect target carry no information.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StRun;
         fetch_pc_q   <= RESET_PC;
         resp_pc_q    <= 32'h0;
         resp_valid_q <= 1'b0;
         hold_instr_q <= 32'h0;
      end else if (redirect) begin
         // Whatever is on imem_data or in the hold buffer is wrong-path.
         state_q      <= StRun;
         fetch_pc_q   <= {redirect_pc[31:2], 2'b00};
         resp_valid_q <= 1'b0;
      end else if (id_stall) begin
         // Entering STALL: memory will now return the next sequential word,
         // so the currently presented instruction must be captured here.
         if (state_q == StRun) begin
            hold_instr_q <= imem_data;
            state_q      <= StStall;
         end
      end else begin
         // fetch_pc has been held stable through any stall, so the data for
         // it is on imem_data again on the cycle after this edge.
         state_q      <= StRun;
         resp_pc_q    <= fetch_pc_q;
         resp_valid_q <= 1'b1;
         fetch_pc_q   <= fetch_pc_q + 32'd4;
      end
   end

   always_comb begin
      imem_addr = {2'b00, fetch_pc_q[31:2]};
      if_instr  = (state_q == StStall) ? hold_instr_q : imem_data;
      if_pc     = resp_pc_q;
      if_valid  = resp_valid_q & ~redirect;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        id_stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;

   int checks;
   int failures;

   // Reference view: the instruction currently presented to decode, and the
   // address of the instruction that follows it on the correct path.
   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_next;

   instr_fetch_unit #(
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .id_stall   (id_stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .if_valid   (if_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mem[k] = 32'h1000_0000 + k for every word index k.
   function automatic logic [31:0] mem_word(input logic [31:0] word_idx);
      return 32'h1000_0000 + word_idx;
   endfunction

   always @(posedge clk) imem_data <= mem_word(imem_addr);

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_pc    = 32'h0;
      m_next  = 32'h0000_0000;
   endtask

   // Called just after a falling edge: drive inputs, check outputs, take the
   // rising edge, update the reference, return at the next falling edge.
   task automatic step(input logic r, input logic [31:0] rpc, input logic s);
      redirect    = r;
      redirect_pc = rpc;
      id_stall    = s;
      #1;
      check_bit("if_valid", if_valid, m_valid & ~r);
      if (m_valid) begin
         check_word("if_pc", if_pc, m_pc);
         check_word("if_instr", if_instr, mem_word({2'b00, m_pc[31:2]}));
      end
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0;
         m_next  = {rpc[31:2], 2'b00};
      end else if (!s) begin
         m_valid = 1'b1;
         m_pc    = m_next;
         m_next  = m_next + 32'd4;
      end
      @(negedge clk);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      id_stall    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check_bit("reset_valid", if_valid, 1'b0);
      check_word("reset_pc", if_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential fetch from RESET_PC, then a 3-cycle stall at if_pc=8
      step(1'b0, 32'h0, 1'b0);  // bubble cycle
      step(1'b0, 32'h0, 1'b0);  // pc 0
      step(1'b0, 32'h0, 1'b0);  // pc 4
      check_word("pre_stall_pc", if_pc, 32'h8);
      repeat (3) step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0);  // release cycle still shows pc 8
      check_word("post_stall_pc", if_pc, 32'hC);
      check_word("post_stall_instr", if_instr, 32'h1000_0003);
      step(1'b0, 32'h0, 1'b0);

      // Redirect to 0x40
      step(1'b1, 32'h40, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      check_word("redir_target_pc", if_pc, 32'h40);
      check_word("redir_target_instr", if_instr, 32'h1000_0010);
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);

      // Redirect together with stall, unaligned target
      step(1'b1, 32'h23, 1'b1);
      step(1'b0, 32'h0, 1'b0);
      check_word("redir_stall_pc", if_pc, 32'h20);
      step(1'b0, 32'h0, 1'b0);

      // Redirect while in STALL
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'h23, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      check_word("redir_in_stall_pc", if_pc, 32'h20);
      check_word("redir_in_stall_instr", if_instr, 32'h1000_0008);
      step(1'b0, 32'h0, 1'b0);

      // Asynchronous reset in the middle of a stall
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("async_reset_valid", if_valid, 1'b0);
      check_word("async_reset_pc", if_pc, 32'h0);
      model_reset();
      @(negedge clk);
      id_stall = 1'b0;
      rst_n    = 1'b1;
      repeat (5) step(1'b0, 32'h0, 1'b0);

      // PC wrap at the top of the address space
      step(1'b1, 32'hFFFF_FFF8, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      check_word("wrap_pc0", if_pc, 32'hFFFF_FFF8);
      step(1'b0, 32'h0, 1'b0);
      check_word("wrap_pc1", if_pc, 32'hFFFF_FFFC);
      step(1'b0, 32'h0, 1'b0);
      check_word("wrap_pc2", if_pc, 32'h0000_0000);
      step(1'b0, 32'h0, 1'b0);

      // Randomized mix of stalls and redirects
      for (int i = 0; i < 400; i++) begin
         logic        r;
         logic        s;
         logic [31:0] tgt;
         r   = ($urandom_range(0, 9) == 0);
         s   = ($urandom_range(0, 9) < 3);
         tgt = $urandom();
         if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
         step(r, tgt, s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
